// File: rtl/eth_vlg_pkg.sv
// Shared Ethernet receive-path definitions.
//   - EtherType constants for ARP and IPv4
//   - mac_addr_t: packed 48-bit MAC address
//   - MAC_BCAST: broadcast destination address
//   - rx_demux_state_t: receive demultiplexer FSM states
package eth_vlg_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef logic [47:0] mac_addr_t;

  localparam mac_addr_t MAC_BCAST = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned RX_LEN_W = 14;
  localparam int unsigned RX_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } rx_demux_state_t;

endpackage

// File: rtl/eth_vlg_sat_cnt.sv
// 16-bit saturating event counter.
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset, clears the count
//   i_inc    amount to add this cycle (0, 1 or 2)
//   o_cnt    registered count, sticks at all-ones
module eth_vlg_sat_cnt
  import eth_vlg_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_inc,
  output logic [RX_CNT_W-1:0] o_cnt
);

  logic [RX_CNT_W-1:0] r_cnt;
  logic [RX_CNT_W:0]   w_sum;

  // One extra bit catches the carry out, which means the count would wrap.
  assign w_sum = {1'b0, r_cnt} + {{(RX_CNT_W - 1){1'b0}}, i_inc};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_sum[RX_CNT_W]) begin
      r_cnt <= '1;
    end else begin
      r_cnt <= w_sum[RX_CNT_W-1:0];
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/eth_vlg_rx_demux.sv
// Receive frame dispatcher: filters on destination MAC, routes by EtherType to one of N
// consumer ports with one cycle of latency, and drops unknown, misaddressed, errored and
// oversized frames while keeping saturating forward/drop counters.
//   clk, rst                    clock, asynchronous active-low reset
//   dev_mac                     local MAC address, compared on every sof beat
//   in_dat/val/sof/eof/err      MAC receive byte stream (no backpressure)
//   in_dst, in_ethertype        header fields, valid on the sof beat
//   out_dat/sof/eof/err         shared registered byte and flags
//   out_val                     per-port valid, at most one bit set
//   cnt_fwd, cnt_drop           saturating frame counters
module eth_vlg_rx_demux
  import eth_vlg_pkg::*;
#(
  parameter int unsigned         N          = 2,
  parameter logic [0:N-1][15:0]  ETHERTYPES = {ETHERTYPE_ARP, ETHERTYPE_IPV4},
  parameter int unsigned         MAX_LEN    = 1500
) (
  input  logic                clk,
  input  logic                rst,
  input  mac_addr_t           dev_mac,
  input  logic [7:0]          in_dat,
  input  logic                in_val,
  input  logic                in_sof,
  input  logic                in_eof,
  input  logic                in_err,
  input  mac_addr_t           in_dst,
  input  logic [15:0]         in_ethertype,
  output logic [7:0]          out_dat,
  output logic                out_sof,
  output logic                out_eof,
  output logic                out_err,
  output logic [N-1:0]        out_val,
  output logic [RX_CNT_W-1:0] cnt_fwd,
  output logic [RX_CNT_W-1:0] cnt_drop
);

  localparam int unsigned SelW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RX_LEN_W-1:0] MaxLen = RX_LEN_W'(MAX_LEN);

  rx_demux_state_t     r_state, w_state;
  logic [SelW-1:0]     r_sel, w_sel;
  logic [RX_LEN_W-1:0] r_len, w_len;
  logic                r_err_seen, w_err_seen;
  logic [N-1:0]        r_val, w_val;
  logic [7:0]          r_dat, w_dat;
  logic                r_sof, w_sof, r_eof, w_eof, r_err, w_err;
  logic [1:0]          w_inc_fwd, w_inc_drop;

  logic                w_addr_ok, w_hit, w_accept;
  logic [SelW-1:0]     w_hit_idx;
  logic [N-1:0]        w_hit_oh, w_sel_oh;
  logic [RX_LEN_W-1:0] w_len_cur;
  logic                w_end_err;

  assign w_addr_ok = (in_dst == dev_mac) || (in_dst == MAC_BCAST);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (in_ethertype == ETHERTYPES[k]) begin
        w_hit     = 1'b1;
        w_hit_idx = SelW'(k);
      end
    end
  end

  always_comb begin
    w_hit_oh = '0;
    w_sel_oh = '0;
    for (int k = 0; k < N; k++) begin
      w_hit_oh[k] = (w_hit_idx == SelW'(k));
      w_sel_oh[k] = (r_sel == SelW'(k));
    end
  end

  assign w_accept  = w_addr_ok & w_hit;
  // r_len counts bytes already forwarded; w_len_cur is the position of this beat.
  assign w_len_cur = r_len + RX_LEN_W'(1);
  assign w_end_err = r_err_seen | in_err;

  always_comb begin
    w_state    = r_state;
    w_sel      = r_sel;
    w_len      = r_len;
    w_err_seen = r_err_seen;
    w_val      = '0;
    w_dat      = r_dat;
    w_sof      = 1'b0;
    w_eof      = 1'b0;
    w_err      = 1'b0;
    w_inc_fwd  = 2'd0;
    w_inc_drop = 2'd0;
    if (in_val) begin
      case (r_state)
        FWD: begin
          if (in_sof) begin
            // Old frame never saw eof: close it with an error terminator, and the new
            // frame is discarded, so both count as drops.
            w_val      = w_sel_oh;
            w_dat      = 8'h00;
            w_eof      = 1'b1;
            w_err      = 1'b1;
            w_inc_drop = 2'd2;
            w_state    = in_eof ? IDLE : DROP;
          end else begin
            w_val      = w_sel_oh;
            w_dat      = in_dat;
            w_len      = w_len_cur;
            w_err_seen = w_end_err;
            if (in_eof) begin
              w_eof   = 1'b1;
              w_err   = w_end_err;
              w_state = IDLE;
              if (w_end_err) w_inc_drop = 2'd1;
              else           w_inc_fwd  = 2'd1;
            end else if (w_len_cur == MaxLen) begin
              w_eof      = 1'b1;
              w_err      = 1'b1;
              w_inc_drop = 2'd1;
              w_state    = DROP;
            end
          end
        end
        default: begin
          // IDLE and DROP take the same decision on a sof beat.
          if (in_sof) begin
            if (w_accept) begin
              w_sel      = w_hit_idx;
              w_len      = RX_LEN_W'(1);
              w_err_seen = in_err;
              w_val      = w_hit_oh;
              w_dat      = in_dat;
              w_sof      = 1'b1;
              if (in_eof) begin
                w_eof   = 1'b1;
                w_err   = in_err;
                w_state = IDLE;
                if (in_err) w_inc_drop = 2'd1;
                else        w_inc_fwd  = 2'd1;
              end else begin
                w_state = FWD;
              end
            end else begin
              w_inc_drop = 2'd1;
              w_state    = in_eof ? IDLE : DROP;
            end
          end else if ((r_state == DROP) && in_eof) begin
            w_state = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_len      <= '0;
      r_err_seen <= 1'b0;
      r_val      <= '0;
      r_dat      <= 8'h00;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sel      <= w_sel;
      r_len      <= w_len;
      r_err_seen <= w_err_seen;
      r_val      <= w_val;
      r_dat      <= w_dat;
      r_sof      <= w_sof;
      r_eof      <= w_eof;
      r_err      <= w_err;
    end
  end

  eth_vlg_sat_cnt u_cnt_fwd (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_inc_fwd),
    .o_cnt   (cnt_fwd)
  );

  eth_vlg_sat_cnt u_cnt_drop (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_inc   (w_inc_drop),
    .o_cnt   (cnt_drop)
  );

  assign out_val = r_val;
  assign out_dat = r_dat;
  assign out_sof = r_sof;
  assign out_eof = r_eof;
  assign out_err = r_err;

endmodule

// File: tb/tb_eth_vlg_rx_demux.sv
// Self-checking bench for eth_vlg_rx_demux (N=2, MAX_LEN=64): a table of single-beat
// vectors followed by whole-frame sequences, oversize, counter saturation and async reset.
module tb_eth_vlg_rx_demux;
  import eth_vlg_pkg::*;

  localparam int unsigned MAXL = 64;
  localparam mac_addr_t MY    = 48'h02_00_00_00_00_AA;
  localparam mac_addr_t OTHER = 48'h02_00_00_00_00_01;
  localparam mac_addr_t BC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ARP = 16'h0806;
  localparam logic [15:0] IP4 = 16'h0800;
  localparam logic [15:0] IP6 = 16'h86DD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mac_addr_t   dev_mac;
  logic [7:0]  in_dat;
  logic        in_val, in_sof, in_eof, in_err;
  mac_addr_t   in_dst;
  logic [15:0] in_ethertype;
  logic [7:0]  out_dat;
  logic        out_sof, out_eof, out_err;
  logic [1:0]  out_val;
  logic [15:0] cnt_fwd, cnt_drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eth_vlg_rx_demux #(
    .N          (2),
    .ETHERTYPES ({16'h0806, 16'h0800}),
    .MAX_LEN    (MAXL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dev_mac      (dev_mac),
    .in_dat       (in_dat),
    .in_val       (in_val),
    .in_sof       (in_sof),
    .in_eof       (in_eof),
    .in_err       (in_err),
    .in_dst       (in_dst),
    .in_ethertype (in_ethertype),
    .out_dat      (out_dat),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .out_err      (out_err),
    .out_val      (out_val),
    .cnt_fwd      (cnt_fwd),
    .cnt_drop     (cnt_drop)
  );

  typedef struct {
    logic        v, s, e, r;
    logic [7:0]  d;
    mac_addr_t   dst;
    logic [15:0] et;
    logic [1:0]  xv;
    logic [7:0]  xd;
    logic        xs, xe, xr;
    logic [15:0] xf, xdr;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one input beat at the falling edge; return 1 ns after the capturing edge.
  task automatic drive(input logic v, input logic s, input logic e, input logic r,
                       input logic [7:0] d, input mac_addr_t dst, input logic [15:0] et);
    @(negedge clk);
    in_val = v; in_sof = s; in_eof = e; in_err = r;
    in_dat = d; in_dst = dst; in_ethertype = et;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    in_dat = 8'h00; in_dst = '0; in_ethertype = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Whole frame; port < 0 means the frame must not appear on any port.
  task automatic send_frame(input int len, input mac_addr_t dst, input logic [15:0] et,
                            input int err_at, input int port, input string tag);
    int         lim;
    logic       seen;
    logic [7:0] d;
    logic [1:0] ev;
    lim  = (len > int'(MAXL)) ? int'(MAXL) : len;
    seen = 1'b0;
    ev   = (port == 0) ? 2'b01 : 2'b10;
    for (int i = 1; i <= len; i++) begin
      d = 8'(i * 3 + 1);
      drive(1'b1, i == 1, i == len, i == err_at, d, dst, et);
      if (port >= 0 && i <= lim) begin
        seen = seen | (i == err_at);
        chk({tag, " val"}, 64'(out_val), 64'(ev));
        chk({tag, " dat"}, 64'(out_dat), 64'(d));
        chk({tag, " sof"}, 64'(out_sof), 64'(i == 1));
        chk({tag, " eof"}, 64'(out_eof), 64'(i == lim));
        if (i == lim) chk({tag, " err"}, 64'(out_err), 64'(seen || (len > int'(MAXL))));
      end else begin
        chk({tag, " no val"}, 64'(out_val), 64'(0));
      end
    end
  endtask

  function automatic vec_t mk(input logic v, s, e, r, input logic [7:0] d, input mac_addr_t dst,
                              input logic [15:0] et, input logic [1:0] xv, input logic [7:0] xd,
                              input logic xs, xe, xr, input logic [15:0] xf, xdr);
    vec_t t;
    t.v = v; t.s = s; t.e = e; t.r = r; t.d = d; t.dst = dst; t.et = et;
    t.xv = xv; t.xd = xd; t.xs = xs; t.xe = xe; t.xr = xr; t.xf = xf; t.xdr = xdr;
    return t;
  endfunction

  initial begin
    dev_mac = MY;
    idle_inputs();

    //            v  s  e  r  dat    dst    et    xv     xdat   xs xe xr fwd drop
    tbl[0]  = mk(0, 0, 0, 0, 8'h00, MY,    IP4, 2'b00, 8'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 0, 8'h11, BC,    ARP, 2'b01, 8'h11, 1, 1, 0, 1, 0);
    tbl[2]  = mk(1, 1, 0, 0, 8'h21, MY,    IP4, 2'b10, 8'h21, 1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 8'hEE, MY,    IP4, 2'b00, 8'h00, 0, 0, 0, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 8'h22, MY,    IP4, 2'b10, 8'h22, 0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 1, 0, 8'h23, MY,    IP4, 2'b10, 8'h23, 0, 1, 0, 2, 0);
    tbl[6]  = mk(1, 1, 0, 0, 8'h31, MY,    IP6, 2'b00, 8'h00, 0, 0, 0, 2, 1);
    tbl[7]  = mk(1, 0, 0, 0, 8'h32, MY,    IP4, 2'b00, 8'h00, 0, 0, 0, 2, 1);
    tbl[8]  = mk(1, 1, 0, 0, 8'h41, MY,    IP4, 2'b10, 8'h41, 1, 0, 0, 2, 1);
    tbl[9]  = mk(1, 1, 0, 0, 8'h51, BC,    ARP, 2'b10, 8'h00, 0, 1, 1, 2, 3);
    tbl[10] = mk(1, 0, 1, 0, 8'h52, MY,    IP4, 2'b00, 8'h00, 0, 0, 0, 2, 3);
    tbl[11] = mk(1, 1, 1, 0, 8'h55, OTHER, IP4, 2'b00, 8'h00, 0, 0, 0, 2, 4);
    tbl[12] = mk(1, 1, 0, 0, 8'h61, MY,    IP4, 2'b10, 8'h61, 1, 0, 0, 2, 4);
    tbl[13] = mk(1, 0, 0, 1, 8'h62, MY,    IP4, 2'b10, 8'h62, 0, 0, 0, 2, 4);
    tbl[14] = mk(1, 0, 1, 0, 8'h63, MY,    IP4, 2'b10, 8'h63, 0, 1, 1, 2, 5);
    tbl[15] = mk(1, 1, 1, 1, 8'h71, BC,    ARP, 2'b01, 8'h71, 1, 1, 1, 2, 6);
    tbl[16] = mk(1, 1, 0, 0, 8'h81, MY,    ARP, 2'b01, 8'h81, 1, 0, 0, 2, 6);
    tbl[17] = mk(1, 1, 1, 0, 8'h82, MY,    IP6, 2'b01, 8'h00, 0, 1, 1, 2, 8);
    tbl[18] = mk(1, 0, 0, 0, 8'h83, MY,    IP4, 2'b00, 8'h00, 0, 0, 0, 2, 8);
    tbl[19] = mk(1, 1, 0, 0, 8'h91, MY,    IP4, 2'b10, 8'h91, 1, 0, 0, 2, 8);
    tbl[20] = mk(1, 0, 1, 0, 8'h92, MY,    IP4, 2'b10, 8'h92, 0, 1, 0, 3, 8);

    // Reset values while rst is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst val",  64'(out_val),  64'(0));
    chk("rst dat",  64'(out_dat),  64'(0));
    chk("rst sof",  64'(out_sof),  64'(0));
    chk("rst eof",  64'(out_eof),  64'(0));
    chk("rst err",  64'(out_err),  64'(0));
    chk("rst fwd",  64'(cnt_fwd),  64'(0));
    chk("rst drop", 64'(cnt_drop), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].r, tbl[i].d, tbl[i].dst, tbl[i].et);
      chk($sformatf("vec%0d val", i), 64'(out_val), 64'(tbl[i].xv));
      if (tbl[i].xv != 2'b00) chk($sformatf("vec%0d dat", i), 64'(out_dat), 64'(tbl[i].xd));
      chk($sformatf("vec%0d sof", i),  64'(out_sof),  64'(tbl[i].xs));
      chk($sformatf("vec%0d eof", i),  64'(out_eof),  64'(tbl[i].xe));
      chk($sformatf("vec%0d err", i),  64'(out_err),  64'(tbl[i].xr));
      chk($sformatf("vec%0d fwd", i),  64'(cnt_fwd),  64'(tbl[i].xf));
      chk($sformatf("vec%0d drop", i), 64'(cnt_drop), 64'(tbl[i].xdr));
    end

    // IPv4 unicast, 46 bytes.
    do_reset();
    send_frame(46, MY, IP4, 0, 1, "ip46");
    chk("ip46 fwd",  64'(cnt_fwd),  64'(1));
    chk("ip46 drop", 64'(cnt_drop), 64'(0));

    // ARP broadcast, then the same frame misaddressed.
    do_reset();
    send_frame(28, BC, ARP, 0, 0, "arp28");
    chk("arp28 fwd", 64'(cnt_fwd), 64'(1));
    send_frame(28, OTHER, ARP, 0, -1, "arpmis");
    chk("arpmis drop", 64'(cnt_drop), 64'(1));
    chk("arpmis fwd",  64'(cnt_fwd),  64'(1));

    // Unknown EtherType, then an IPv4 frame back to back.
    do_reset();
    send_frame(20, MY, IP6, 0, -1, "ip6");
    chk("ip6 drop", 64'(cnt_drop), 64'(1));
    send_frame(30, MY, IP4, 0, 1, "ipnext");
    chk("ipnext fwd",  64'(cnt_fwd),  64'(1));
    chk("ipnext drop", 64'(cnt_drop), 64'(1));

    // Error on byte 10 of 60.
    do_reset();
    send_frame(60, MY, IP4, 10, 1, "iperr");
    chk("iperr drop", 64'(cnt_drop), 64'(1));
    chk("iperr fwd",  64'(cnt_fwd),  64'(0));

    // Oversize, then a sof in the middle of a forwarded frame.
    do_reset();
    send_frame(100, MY, IP4, 0, 1, "over");
    chk("over drop", 64'(cnt_drop), 64'(1));
    chk("over fwd",  64'(cnt_fwd),  64'(0));
    drive(1, 1, 0, 0, 8'hA1, MY, IP4);
    chk("mid sof val", 64'(out_val), 64'(2'b10));
    drive(1, 0, 0, 0, 8'hA2, MY, IP4);
    chk("mid b2 dat", 64'(out_dat), 64'(8'hA2));
    drive(1, 1, 0, 0, 8'hB1, BC, ARP);
    chk("term val", 64'(out_val), 64'(2'b10));
    chk("term dat", 64'(out_dat), 64'(0));
    chk("term sof", 64'(out_sof), 64'(0));
    chk("term eof", 64'(out_eof), 64'(1));
    chk("term err", 64'(out_err), 64'(1));
    chk("term drop", 64'(cnt_drop), 64'(3));
    drive(1, 0, 1, 0, 8'hB2, BC, ARP);
    chk("term tail val", 64'(out_val), 64'(0));
    chk("term tail drop", 64'(cnt_drop), 64'(3));

    // Saturation of the drop counter.
    do_reset();
    for (int i = 0; i < 65534; i++) drive(1, 1, 1, 0, 8'h00, MY, IP6);
    chk("sat preload", 64'(cnt_drop), 64'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 8'h00, MY, IP6);
      chk($sformatf("sat hold%0d", i), 64'(cnt_drop), 64'(16'hFFFF));
    end

    // Asynchronous reset in the middle of a forwarded frame.
    drive(1, 1, 0, 0, 8'hC1, MY, IP4);
    chk("pre-rst val", 64'(out_val), 64'(2'b10));
    drive(1, 0, 0, 0, 8'hC2, MY, IP4);
    #2;
    rst = 1'b0;
    #1;
    chk("async val",  64'(out_val),  64'(0));
    chk("async dat",  64'(out_dat),  64'(0));
    chk("async sof",  64'(out_sof),  64'(0));
    chk("async eof",  64'(out_eof),  64'(0));
    chk("async err",  64'(out_err),  64'(0));
    chk("async drop", 64'(cnt_drop), 64'(0));
    chk("async fwd",  64'(cnt_fwd),  64'(0));
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
